// File: rtl/ram_wb_sc_ctrl.sv
// ---------------------------------------------------------------------------
// ram_wb_sc_ctrl
//
// Wishbone B3 slave controller that sequences one single-port, single-clock
// synchronous RAM. The RAM returns data one cycle after its address and is
// read-first.
//   - Full-word writes go straight to the RAM.
//   - Partial byte-lane writes become a read-modify-write sequence.
//   - Incrementing bursts (linear / wrap4 / wrap8 / wrap16) are streamed at
//     one beat per clock.
//   - Out-of-range word addresses are answered with an error instead of an
//     acknowledge.
//
// Ports
//   wb_clk_i, wb_rst_i   clock (rising edge), asynchronous active-high reset
//   wb_adr_i             byte address; word address = wb_adr_i[ram_adr_width+1:2]
//   wb_dat_i, wb_sel_i   write data and byte enables
//   wb_we_i              1 = write
//   wb_cyc_i, wb_stb_i   bus cycle / strobe; request = cyc & stb
//   wb_cti_i, wb_bte_i   cycle type and burst type
//   wb_dat_o             read data while acking a read, else 0
//   wb_ack_o, wb_err_o   registered acknowledge / error, never both high
//   ram_adr_o            registered RAM word address
//   ram_dat_o            registered RAM write data (merged word)
//   ram_we_o             RAM write enable, high only in the write state
//   ram_dat_i            RAM read data, one cycle after ram_adr_o
// ---------------------------------------------------------------------------
module ram_wb_sc_ctrl #(
  parameter int adr_width     = 32,
  parameter int ram_adr_width = 20,
  parameter int mem_size      = 262144
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [adr_width-1:0]     wb_adr_i,
  input  logic [31:0]              wb_dat_i,
  input  logic [3:0]               wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic [2:0]               wb_cti_i,
  input  logic [1:0]               wb_bte_i,
  output logic [31:0]              wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic [ram_adr_width-1:0] ram_adr_o,
  output logic [31:0]              ram_dat_o,
  output logic                     ram_we_o,
  input  logic [31:0]              ram_dat_i
);

  localparam int c_aw = ram_adr_width;

  // One extra bit so that a depth equal to 2**ram_adr_width still fits.
  localparam logic [c_aw:0] c_mem_size = (c_aw + 1)'(mem_size);

  localparam logic [2:0] c_cti_incr = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RACK,
    S_RMW_RD,
    S_RMW_MRG,
    S_WR,
    S_ACK,
    S_ERR
  } state_t;

  state_t r_state;

  // Set when the prefetched burst address in ram_adr_o lies beyond the RAM.
  logic r_pf_oor;

  logic            w_req;
  logic [c_aw-1:0] w_req_adr;
  logic            w_req_oor;
  logic            w_burst_go;
  logic [c_aw-1:0] w_wrap_mask;
  logic [c_aw:0]   w_inc;
  logic [c_aw:0]   w_next;
  logic            w_next_oor;
  logic [31:0]     w_merged;
  logic            w_unused_adr;

  assign w_req      = wb_cyc_i & wb_stb_i;
  assign w_req_adr  = wb_adr_i[c_aw+1:2];
  assign w_req_oor  = ({1'b0, w_req_adr} >= c_mem_size);
  assign w_burst_go = w_req && (wb_cti_i == c_cti_incr);

  // Byte-lane bits and address bits above the RAM window are ignored.
  assign w_unused_adr = ^{wb_adr_i[adr_width-1:c_aw+2], wb_adr_i[1:0]};

  // NOTE: every variable assigned in an always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    w_wrap_mask = '0;
    case (wb_bte_i)
      2'b01:   w_wrap_mask = c_aw'(3);
      2'b10:   w_wrap_mask = c_aw'(7);
      2'b11:   w_wrap_mask = c_aw'(15);
      default: w_wrap_mask = '0;
    endcase
  end

  // Next burst address: linear keeps the carry so running off the top of the
  // address field is still seen as out of range; wrap bursts only count in
  // the low bits and hold the rest.
  assign w_inc  = {1'b0, ram_adr_o} + (c_aw + 1)'(1);
  assign w_next = (w_wrap_mask == '0) ? w_inc
                : {1'b0, (ram_adr_o & ~w_wrap_mask) | (w_inc[c_aw-1:0] & w_wrap_mask)};
  assign w_next_oor = (w_next >= c_mem_size);

  always_comb begin
    w_merged = ram_dat_i;
    for (int i = 0; i < 4; i++) begin
      if (wb_sel_i[i]) w_merged[8*i +: 8] = wb_dat_i[8*i +: 8];
    end
  end

  // The ack in RACK always belongs to a read beat, so the state alone gates
  // the returned data.
  assign wb_dat_o = (r_state == S_RACK) ? ram_dat_i : 32'h0;

  // NOTE: sequential state uses non-blocking assignments only; the pulse
  // outputs default low at the top of the clocked branch and the states that
  // need them re-assert them, the later assignment winning.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_pf_oor  <= 1'b0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      ram_we_o  <= 1'b0;
      ram_adr_o <= '0;
      ram_dat_o <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      ram_we_o <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_req_oor) begin
              r_state  <= S_ERR;
              wb_err_o <= 1'b1;
            end else begin
              ram_adr_o <= w_req_adr;
              if (!wb_we_i) begin
                r_state  <= S_RD;
                r_pf_oor <= 1'b0;
              end else if (wb_sel_i == 4'hF) begin
                r_state   <= S_WR;
                ram_dat_o <= wb_dat_i;
                ram_we_o  <= 1'b1;
              end else if (wb_sel_i == 4'h0) begin
                // Nothing to write: acknowledge without touching the RAM.
                r_state  <= S_ACK;
                wb_ack_o <= 1'b1;
              end else begin
                r_state <= S_RMW_RD;
              end
            end
          end
        end

        S_RD: begin
          if (!w_req) begin
            r_state   <= S_IDLE;
            ram_adr_o <= '0;
            ram_dat_o <= '0;
          end else begin
            r_state  <= S_RACK;
            wb_ack_o <= 1'b1;
            // Start the prefetch now so the second beat's data is ready in
            // the cycle right after the first ack.
            if (wb_cti_i == c_cti_incr) begin
              ram_adr_o <= w_next[c_aw-1:0];
              r_pf_oor  <= w_next_oor;
            end
          end
        end

        S_RACK: begin
          if (w_burst_go) begin
            if (r_pf_oor) begin
              r_state   <= S_ERR;
              wb_err_o  <= 1'b1;
              ram_adr_o <= '0;
            end else begin
              wb_ack_o  <= 1'b1;
              ram_adr_o <= w_next[c_aw-1:0];
              r_pf_oor  <= w_next_oor;
            end
          end else begin
            // End of burst or master gone: the prefetched word is dropped.
            r_state   <= S_IDLE;
            ram_adr_o <= '0;
            ram_dat_o <= '0;
          end
        end

        S_RMW_RD: begin
          if (!w_req) begin
            r_state   <= S_IDLE;
            ram_adr_o <= '0;
            ram_dat_o <= '0;
          end else begin
            r_state <= S_RMW_MRG;
          end
        end

        S_RMW_MRG: begin
          if (!w_req) begin
            r_state   <= S_IDLE;
            ram_adr_o <= '0;
            ram_dat_o <= '0;
          end else begin
            r_state   <= S_WR;
            ram_dat_o <= w_merged;
            ram_we_o  <= 1'b1;
          end
        end

        // The write commits regardless of the bus from here on.
        S_WR: begin
          r_state  <= S_ACK;
          wb_ack_o <= 1'b1;
        end

        S_ACK, S_ERR: begin
          r_state   <= S_IDLE;
          ram_adr_o <= '0;
          ram_dat_o <= '0;
        end

        default: begin
          r_state   <= S_IDLE;
          ram_adr_o <= '0;
          ram_dat_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_wb_sc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram_wb_sc_ctrl
//
// Bench for ram_wb_sc_ctrl. A behavioural read-first RAM is attached to the
// RAM port; a separate word array holds the expected memory image and is
// updated from the byte-lane write rules. Expected burst address sequences
// are computed arithmetically from the start address and burst type.
// ---------------------------------------------------------------------------
module tb_ram_wb_sc_ctrl;

  localparam int AW = 10;
  localparam int MS = 256;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic [31:0]   wb_adr_i;
  logic [31:0]   wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [2:0]    wb_cti_i;
  logic [1:0]    wb_bte_i;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic [AW-1:0] ram_adr_o;
  logic [31:0]   ram_dat_o;
  logic          ram_we_o;
  logic [31:0]   ram_dat_i;

  // Backdoor load port of the behavioural RAM.
  logic          bd_we;
  logic [AW-1:0] bd_adr;
  logic [31:0]   bd_dat;

  logic [31:0] tb_ram  [1024];
  logic [31:0] ref_mem [1024];

  int n_cmp = 0;
  int n_bad = 0;
  int we_count = 0;
  int overlap_count = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  ram_wb_sc_ctrl #(
    .adr_width    (32),
    .ram_adr_width(AW),
    .mem_size     (MS)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_cti_i (wb_cti_i),
    .wb_bte_i (wb_bte_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .ram_adr_o(ram_adr_o),
    .ram_dat_o(ram_dat_o),
    .ram_we_o (ram_we_o),
    .ram_dat_i(ram_dat_i)
  );

  // Read-first synchronous RAM with one cycle of read latency.
  always @(posedge wb_clk_i) begin
    ram_dat_i <= tb_ram[ram_adr_o];
    if (bd_we) tb_ram[bd_adr] <= bd_dat;
    else if (ram_we_o) tb_ram[ram_adr_o] <= ram_dat_o;
  end

  always @(posedge wb_clk_i) begin
    if (ram_we_o) we_count <= we_count + 1;
  end

  always @(negedge wb_clk_i) begin
    if (wb_ack_o && wb_err_o) overlap_count <= overlap_count + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time %0t reached, required completion before it", $time);
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------ helpers ---
  function automatic void model_write(input int word, input logic [31:0] dat,
                                      input logic [3:0] sel);
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) ref_mem[word][8*b +: 8] = dat[8*b +: 8];
    end
  endfunction

  task automatic poke(input int word, input logic [31:0] val);
    @(posedge wb_clk_i); #1;
    bd_we = 1'b1; bd_adr = AW'(word); bd_dat = val;
    ref_mem[word] = val;
    @(posedge wb_clk_i); #1;
    bd_we = 1'b0;
  endtask

  task automatic bus_drop();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = 3'b000;
  endtask

  // One classic cycle; lat is the cycle index of the response, -1 on timeout.
  task automatic do_single(input logic we, input int word, input logic [31:0] dat,
                           input logic [3:0] sel, output int lat,
                           output logic [31:0] rdat, output logic is_err);
    @(posedge wb_clk_i); #1;
    wb_adr_i = 32'(word << 2); wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
    wb_cti_i = 3'b000; wb_bte_i = 2'b00; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    lat = -1; rdat = '0; is_err = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge wb_clk_i);
      if (wb_ack_o || wb_err_o) begin
        lat = c; rdat = wb_dat_o; is_err = wb_err_o;
        break;
      end
    end
    @(posedge wb_clk_i); #1;
    bus_drop();
  endtask

  // Burst read; expected beat addresses come from the start and burst type.
  task automatic run_burst(input string name, input int start,
                           input logic [1:0] bte, input int nbeats);
    int addr[$];
    int span;
    int lat;
    logic exp_err;
    span = (bte == 2'b00) ? 0 : (bte == 2'b01) ? 4 : (bte == 2'b10) ? 8 : 16;
    for (int i = 0; i < nbeats; i++) begin
      if (span == 0) addr.push_back(start + i);
      else addr.push_back(start - (start % span) + ((start + i) % span));
    end
    @(posedge wb_clk_i); #1;
    wb_adr_i = 32'(addr[0] << 2); wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cti_i = (nbeats == 1) ? 3'b111 : 3'b010; wb_bte_i = bte;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    lat = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge wb_clk_i);
      if (wb_ack_o || wb_err_o) begin
        lat = c;
        break;
      end
    end
    n_cmp++;
    if (lat !== 2) begin
      n_bad++;
      $display("FAIL %s first_beat_latency: got %0d required 2", name, lat);
    end
    if (lat >= 0) begin
      for (int b = 0; b < nbeats; b++) begin
        if (b > 0) @(negedge wb_clk_i);
        exp_err = (addr[b] >= MS);
        n_cmp++;
        if ({wb_ack_o, wb_err_o} !== (exp_err ? 2'b01 : 2'b10)) begin
          n_bad++;
          $display("FAIL %s beat%0d_resp (word %0d): ack/err got %b%b required %b",
                   name, b, addr[b], wb_ack_o, wb_err_o, exp_err ? 2'b01 : 2'b10);
        end else if (!exp_err) begin
          n_cmp++;
          if (wb_dat_o !== ref_mem[addr[b]]) begin
            n_bad++;
            $display("FAIL %s beat%0d_data (word %0d): got %h required %h",
                     name, b, addr[b], wb_dat_o, ref_mem[addr[b]]);
          end
        end
        if (exp_err || b == nbeats - 1) break;
        @(posedge wb_clk_i); #1;
        wb_adr_i = 32'(addr[b+1] << 2);
        wb_cti_i = (b + 1 == nbeats - 1) ? 3'b111 : 3'b010;
      end
    end
    @(posedge wb_clk_i); #1;
    bus_drop();
    @(negedge wb_clk_i);
    n_cmp++;
    if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin
      n_bad++;
      $display("FAIL %s after_burst: ack/err got %b%b required 00", name, wb_ack_o, wb_err_o);
    end
  endtask

  // -------------------------------------------------------------- tests ---
  task automatic test_reset();
    wb_rst_i = 1'b1;
    bd_we = 1'b0; bd_adr = '0; bd_dat = '0;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_bte_i = '0;
    bus_drop();
    // Preload the whole RAM while reset is held.
    for (int i = 0; i < 1024; i++) begin
      @(posedge wb_clk_i); #1;
      bd_we = 1'b1; bd_adr = AW'(i); bd_dat = $urandom;
      ref_mem[i] = bd_dat;
    end
    @(posedge wb_clk_i); #1;
    bd_we = 1'b0;
    @(negedge wb_clk_i);
    n_cmp++;
    if ({wb_ack_o, wb_err_o, ram_we_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: ack/err/we got %b%b%b required 000", wb_ack_o, wb_err_o, ram_we_o);
    end
    n_cmp++;
    if (ram_adr_o !== '0) begin
      n_bad++;
      $display("FAIL reset_ram_adr: got %h required 0", ram_adr_o);
    end
    n_cmp++;
    if (ram_dat_o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_ram_dat: got %h required 0", ram_dat_o);
    end
    n_cmp++;
    if (wb_dat_o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_wb_dat: got %h required 0", wb_dat_o);
    end
    wb_rst_i = 1'b0;
  endtask

  task automatic test_single_read();
    poke(16, 32'hDEADBEEF);
    @(posedge wb_clk_i); #1;
    wb_adr_i = 32'(16 << 2); wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cti_i = 3'b000; wb_bte_i = 2'b00; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge wb_clk_i);
      n_cmp++;
      if (wb_ack_o !== 1'(c == 2)) begin
        n_bad++;
        $display("FAIL single_read_ack_cycle%0d: got %b required %b", c, wb_ack_o, c == 2);
      end
      if (c == 2) begin
        n_cmp++;
        if (wb_dat_o !== 32'hDEADBEEF) begin
          n_bad++;
          $display("FAIL single_read_data: got %h required deadbeef", wb_dat_o);
        end
        @(posedge wb_clk_i); #1;
        bus_drop();
      end
      if (c == 3) begin
        n_cmp++;
        if (wb_dat_o !== 32'h0) begin
          n_bad++;
          $display("FAIL single_read_dat_idle: got %h required 0", wb_dat_o);
        end
      end
    end
  endtask

  task automatic test_full_write();
    int lat; logic [31:0] rd; logic er; int we0;
    we0 = we_count;
    do_single(1'b1, 32, 32'h11223344, 4'hF, lat, rd, er);
    model_write(32, 32'h11223344, 4'hF);
    n_cmp++;
    if (lat !== 2 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL full_write_ack: latency %0d err %b required latency 2 err 0", lat, er);
    end
    n_cmp++;
    if (we_count - we0 !== 1) begin
      n_bad++;
      $display("FAIL full_write_we_pulses: got %0d required 1", we_count - we0);
    end
    do_single(1'b0, 32, 32'h0, 4'hF, lat, rd, er);
    n_cmp++;
    if (lat !== 2 || rd !== 32'h11223344) begin
      n_bad++;
      $display("FAIL full_write_readback: latency %0d data %h required latency 2 data 11223344", lat, rd);
    end
  endtask

  task automatic test_partial_write();
    int lat; logic [31:0] rd; logic er; int we0;
    we0 = we_count;
    do_single(1'b1, 32, 32'hAABBCCDD, 4'b0101, lat, rd, er);
    model_write(32, 32'hAABBCCDD, 4'b0101);
    n_cmp++;
    if (lat !== 4 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL partial_write_ack: latency %0d err %b required latency 4 err 0", lat, er);
    end
    n_cmp++;
    if (tb_ram[32] !== 32'h11BB33DD) begin
      n_bad++;
      $display("FAIL partial_write_mem: got %h required 11bb33dd", tb_ram[32]);
    end
    n_cmp++;
    if (we_count - we0 !== 1) begin
      n_bad++;
      $display("FAIL partial_write_we_pulses: got %0d required 1", we_count - we0);
    end
  endtask

  task automatic test_sel_zero();
    int lat; logic [31:0] rd; logic er; int we0;
    we0 = we_count;
    do_single(1'b1, 40, 32'h5A5A5A5A, 4'h0, lat, rd, er);
    n_cmp++;
    if (lat !== 1 || er !== 1'b0 || we_count - we0 !== 0) begin
      n_bad++;
      $display("FAIL sel_zero: latency %0d err %b we pulses %0d required 1/0/0", lat, er, we_count - we0);
    end
    n_cmp++;
    if (tb_ram[40] !== ref_mem[40]) begin
      n_bad++;
      $display("FAIL sel_zero_mem: got %h required %h", tb_ram[40], ref_mem[40]);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd; logic er; int we0;
    for (int w = 0; w < 2; w++) begin
      we0 = we_count;
      do_single(1'(w), MS, 32'hFFFFFFFF, 4'hF, lat, rd, er);
      n_cmp++;
      if (lat !== 1 || er !== 1'b1 || we_count - we0 !== 0) begin
        n_bad++;
        $display("FAIL oor_we%0d: latency %0d err %b we pulses %0d required 1/1/0", w, lat, er, we_count - we0);
      end
      @(negedge wb_clk_i);
      n_cmp++;
      if (wb_err_o !== 1'b0 || wb_ack_o !== 1'b0) begin
        n_bad++;
        $display("FAIL oor_we%0d_pulse_width: ack/err got %b%b required 00", w, wb_ack_o, wb_err_o);
      end
    end
  endtask

  task automatic test_bursts();
    for (int i = 4; i < 8; i++) poke(i, 32'hC0DE0000 + 32'(i));
    run_burst("wrap4_at6", 6, 2'b01, 4);
    run_burst("linear_end", MS - 2, 2'b00, 4);
    run_burst("wrap8", 13, 2'b10, 8);
    run_burst("wrap16", 37, 2'b11, 16);
  endtask

  task automatic test_abort();
    int we0; int seen;
    for (int w = 0; w < 2; w++) begin
      we0 = we_count;
      seen = 0;
      @(posedge wb_clk_i); #1;
      wb_adr_i = 32'(50 << 2); wb_dat_i = 32'h12345678; wb_sel_i = 4'b0011;
      wb_we_i = 1'(w); wb_cti_i = 3'b000; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      @(posedge wb_clk_i); #1;
      bus_drop();
      for (int c = 0; c < 6; c++) begin
        @(negedge wb_clk_i);
        if (wb_ack_o || wb_err_o) seen++;
      end
      n_cmp++;
      if (seen !== 0 || we_count - we0 !== 0) begin
        n_bad++;
        $display("FAIL abort_we%0d: responses %0d we pulses %0d required 0/0", w, seen, we_count - we0);
      end
    end
  endtask

  task automatic test_reset_in_merge();
    int we0;
    poke(48, 32'h01020304);
    we0 = we_count;
    @(posedge wb_clk_i); #1;
    wb_adr_i = 32'(48 << 2); wb_dat_i = 32'hFFFFFFFF; wb_sel_i = 4'b1000;
    wb_we_i = 1'b1; wb_cti_i = 3'b000; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    #1;
    n_cmp++;
    if ({wb_ack_o, wb_err_o, ram_we_o} !== 3'b000 || ram_adr_o !== '0 || ram_dat_o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_in_merge_outputs: ack/err/we %b%b%b adr %h dat %h required all 0",
               wb_ack_o, wb_err_o, ram_we_o, ram_adr_o, ram_dat_o);
    end
    bus_drop();
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    n_cmp++;
    if (we_count - we0 !== 0 || tb_ram[48] !== 32'h01020304) begin
      n_bad++;
      $display("FAIL reset_in_merge_mem: we pulses %0d word %h required 0 and 01020304",
               we_count - we0, tb_ram[48]);
    end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd; logic er; int we0;
    int word; logic we; logic [3:0] sel; logic [31:0] dat;
    int exp_lat; logic exp_err; logic exp_we; logic [31:0] exp_rd;
    int start; logic [1:0] bte;
    for (int t = 0; t < 150; t++) begin
      word = $urandom_range(0, MS + 40);
      we   = 1'($urandom_range(0, 1));
      sel  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) sel = 4'hF;
      dat  = $urandom;
      exp_err = (word >= MS);
      exp_lat = exp_err ? 1 : !we ? 2 : (sel == 4'hF) ? 2 : (sel == 4'h0) ? 1 : 4;
      exp_we  = !exp_err && we && (sel != 4'h0);
      exp_rd  = (!exp_err && !we) ? ref_mem[word] : 32'h0;
      we0 = we_count;
      do_single(we, word, dat, sel, lat, rd, er);
      if (exp_we) model_write(word, dat, sel);
      n_cmp++;
      if (lat !== exp_lat || er !== exp_err || rd !== exp_rd || (we_count - we0) !== int'(exp_we)) begin
        n_bad++;
        $display("FAIL random%0d (we %b word %0d sel %b): lat %0d err %b dat %h wes %0d required %0d %b %h %0d",
                 t, we, word, sel, lat, er, rd, we_count - we0, exp_lat, exp_err, exp_rd, int'(exp_we));
      end
    end
    for (int t = 0; t < 30; t++) begin
      bte   = 2'($urandom_range(0, 3));
      start = (bte == 2'b00 && $urandom_range(0, 1) == 1) ? $urandom_range(MS - 6, MS - 1)
                                                          : $urandom_range(0, MS - 1);
      run_burst($sformatf("rand_burst%0d", t), start, bte, $urandom_range(1, 8));
    end
  endtask

  task automatic test_final_image();
    int bad_words;
    bad_words = 0;
    for (int i = 0; i < MS; i++) begin
      if (tb_ram[i] !== ref_mem[i]) bad_words++;
    end
    n_cmp++;
    if (bad_words !== 0) begin
      n_bad++;
      $display("FAIL final_image: %0d words differ, required 0", bad_words);
    end
    n_cmp++;
    if (overlap_count !== 0) begin
      n_bad++;
      $display("FAIL ack_err_overlap: %0d cycles with both high, required 0", overlap_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_full_write();
    test_partial_write();
    test_sel_zero();
    test_out_of_range();
    test_bursts();
    test_abort();
    test_reset_in_merge();
    test_random();
    test_final_image();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_wb_sc_ctrl.md
Name: ram_wb_sc_ctrl

Overview:
- Wishbone B3 slave controller that sequences a single-port, single-clock synchronous RAM.
- RAM contract:
  - one read port;
  - data appears one cycle after the address;
  - read-first (on a write cycle the read data returns the old word).
- Converts byte-lane writes into read-modify-write (RMW) sequences, streams linear/wrap burst reads at one beat per clock, and rejects out-of-range addresses with an error response.
- Sits between the bus arbiter and the on-chip RAM array.

Parameters:
- adr_width, 32: Wishbone byte-address width.
- ram_adr_width, 20: RAM word-address width.
- mem_size, 262144: RAM depth in 32-bit words; word addresses >= mem_size are out of range.

Ports:
- wb_clk_i  in  1  clock; all logic is on the rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wb_adr_i  in  adr_width  byte address; word address = wb_adr_i[ram_adr_width+1:2].
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte enables; bit n selects dat[8n+7:8n].
- wb_we_i  in  1  1 = write.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst.
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- wb_dat_o  out  32  read data; driven from ram_dat_i while acking a read, else 0.
- wb_ack_o  out  1  registered acknowledge.
- wb_err_o  out  1  registered error response.
- ram_adr_o  out  ram_adr_width  RAM word address (registered).
- ram_dat_o  out  32  RAM write data (registered merged word).
- ram_we_o  out  1  RAM write enable.
- ram_dat_i  in  32  RAM read data, one cycle after ram_adr_o.

Behaviour:
- Reset (async) and all returns to IDLE: state = IDLE; wb_ack_o = 0, wb_err_o = 0, ram_we_o = 0; ram_adr_o = 0, ram_dat_o = 0.
- Request = wb_cyc_i & wb_stb_i, sampled only in IDLE.
- State IDLE:
  - On request with out-of-range word address: go to ERR.
  - Otherwise register ram_adr_o, then:
    - read: go to RD;
    - write with wb_sel_i == 4'hF: go to WR, ram_dat_o = wb_dat_i;
    - write with partial sel: go to RMW_RD.
  - Writes with wb_sel_i == 0 go to ACK directly; no RAM write.
- State RD: RAM read in flight; next state RACK.
- State RACK:
  - wb_ack_o = 1; wb_dat_o = ram_dat_i.
  - Read latency: ack in the 2nd cycle after the request is first sampled.
  - If wb_cti_i == 010 and request is still high: advance ram_adr_o per BTE in this same cycle and stay in RACK, giving back-to-back acks.
  - Linear: +1. Wrap4/8/16: increment the low 2/3/4 bits only; the upper bits are held.
  - If wb_cti_i is 000 or 111, or the request drops: go to IDLE. The in-flight prefetch is discarded.
  - A burst that increments past mem_size-1 gets err on that beat instead of ack, then goes to IDLE.
- State RMW_RD: waits one cycle for the old word; next state RMW_MRG.
- State RMW_MRG: ram_dat_o = byte-lane merge (sel lane ? wb_dat_i : ram_dat_i); next state WR.
- State WR:
  - ram_we_o = 1 for exactly one cycle; next state ACK.
  - Once WR is entered the write always commits, even if wb_cyc_i drops.
- State ACK: wb_ack_o = 1 for one cycle; next state IDLE.
- Write latencies: full-word ack at request+2; partial ack at request+4.
- Write bursts are served as back-to-back single writes. Each beat is re-sampled in IDLE at the next address presented by the master.
- State ERR: wb_err_o = 1 for one cycle; next state IDLE. No RAM access.
- wb_ack_o and wb_err_o are never high together.
- Master abort: request deasserted in RD, RMW_RD or RMW_MRG means go to IDLE with no write and no ack.
- ram_we_o is high only in WR.

Test Plan:
- Reset, then single read of word 0x10 preloaded with 0xDEADBEEF -> ack high exactly at cycle 2 with wb_dat_o = 0xDEADBEEF; ack low in cycles 0, 1 and 3.
- Write 0x11223344 with sel F to 0x20, then read it back -> ram_we_o pulses once, ack at cycle 2, readback 0x11223344.
- Word 0x20 holds 0x11223344; write 0xAABBCCDD with sel 0101 -> ack at cycle 4; memory holds 0x11BB33DD.
- Wrap4 burst read starting at word 6, 4 beats, cti 010,010,010,111 -> acks on 4 consecutive cycles; addresses 6,7,4,5; state IDLE afterwards.
- Access to word mem_size -> wb_err_o for 1 cycle, no ack, ram_we_o stays 0.
- Partial write with wb_rst_i asserted during RMW_MRG -> outputs are 0 immediately; ram_we_o never pulses and memory is unchanged.
